image_bram_2d: RTL and testbench

Parametrised 2-D image frame buffer for the filter datapath. Pixels are written in raster order through a streaming port with internal row/column counters. Pixels are read by random (row, column) coordinates with a registered 1-cycle read and explicit valid. Out-of-range coordinates return a pad value, so convolution windows can straddle image borders without external clamping logic.

---
 rtl/image_bram_2d.sv | 126 ++++++++++++
 tb/tb_image_bram_2d.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/image_bram_2d.sv
// image_bram_2d: 2-D frame buffer. Raster-order streaming writes with
// internal row/column counters, random-access (row, col) reads with a
// one-cycle registered result, and pad values for out-of-range coordinates.
module image_bram_2d #(
  parameter int                DATA_W  = 8,
  parameter int                ROWS    = 12,
  parameter int                COLS    = 12,
  parameter int                ADDR_W  = 4,
  parameter logic [DATA_W-1:0] PAD_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_start,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_row,
  output logic [ADDR_W-1:0] wr_col,
  output logic              wr_done,
  output logic              frame_valid,
  input  logic              rd_v,
  input  logic [ADDR_W-1:0] rd_x,
  input  logic [ADDR_W-1:0] rd_y,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              rd_oob
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pixel storage, flattened row-major; no reset so it maps onto block RAM.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] r_wr_row;
  logic [ADDR_W-1:0] r_wr_col;
  logic              r_wr_done;
  logic              r_frame_valid;
  logic [DATA_W-1:0] r_rd_q;
  logic              r_rd_valid;
  logic              r_rd_oob;
  logic              r_rd_loaded;

  logic [ADDR_W-1:0] w_row_cur;
  logic [ADDR_W-1:0] w_col_cur;
  logic              w_row_last;
  logic              w_col_last;
  logic              w_frame_last;
  logic              w_rd_in_range;
  logic [MEM_AW-1:0] w_wr_addr;
  logic [MEM_AW-1:0] w_rd_addr;

  // wr_start overrides the stored position so a same-cycle write lands at (0,0).
  assign w_row_cur     = wr_start ? '0 : r_wr_row;
  assign w_col_cur     = wr_start ? '0 : r_wr_col;
  assign w_row_last    = (int'(w_row_cur) == ROWS - 1);
  assign w_col_last    = (int'(w_col_cur) == COLS - 1);
  assign w_frame_last  = wr_en & w_row_last & w_col_last;
  assign w_wr_addr     = MEM_AW'(int'(w_row_cur) * COLS + int'(w_col_cur));
  assign w_rd_in_range = (int'(rd_x) < ROWS) && (int'(rd_y) < COLS);
  assign w_rd_addr     = MEM_AW'(int'(rd_x) * COLS + int'(rd_y));

  // Raster write position, end-of-frame pulse and frame-complete flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_row      <= '0;
      r_wr_col      <= '0;
      r_wr_done     <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_wr_done <= w_frame_last;
      if (wr_en) begin
        if (w_col_last) begin
          r_wr_col <= '0;
          r_wr_row <= w_row_last ? '0 : w_row_cur + 1'b1;
        end else begin
          r_wr_col <= w_col_cur + 1'b1;
          r_wr_row <= w_row_cur;
        end
      end else begin
        r_wr_row <= w_row_cur;
        r_wr_col <= w_col_cur;
      end
      if (w_frame_last) begin
        r_frame_valid <= 1'b1;
      end else if (wr_start) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  // Single write port and single registered read port; read-first on collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[w_wr_addr] <= wr_data;
    end
    if (rd_v && w_rd_in_range) begin
      r_rd_q <= r_mem[w_rd_addr];
    end
  end

  // Read qualifiers; rd_oob and the loaded flag hold while no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid  <= 1'b0;
      r_rd_oob    <= 1'b0;
      r_rd_loaded <= 1'b0;
    end else begin
      r_rd_valid <= rd_v;
      if (rd_v) begin
        r_rd_oob    <= ~w_rd_in_range;
        r_rd_loaded <= 1'b1;
      end
    end
  end

  // Output select from registered state: zero until the first read after reset,
  // pad for an out-of-range read, otherwise the RAM output register.
  assign rd_data       = !r_rd_loaded ? '0 : (r_rd_oob ? PAD_VAL : r_rd_q);
  assign rd_data_valid = r_rd_valid;
  assign rd_oob        = r_rd_oob;
  assign wr_row        = r_wr_row;
  assign wr_col        = r_wr_col;
  assign wr_done       = r_wr_done;
  assign frame_valid   = r_frame_valid;

endmodule

// File: tb/tb_image_bram_2d.sv
// tb_image_bram_2d: directed scenarios plus randomized traffic on a 12x12
// instance checked against a frame-array model, and a directed 4x6 instance.
module tb_image_bram_2d;

  localparam int R = 12;
  localparam int C = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 12x12 instance
  logic       a_wr_start, a_wr_en, a_rd_v;
  logic [7:0] a_wr_data, a_rd_data;
  logic [3:0] a_wr_row, a_wr_col, a_rd_x, a_rd_y;
  logic       a_wr_done, a_fv, a_rd_dv, a_rd_oob;

  // 4x6 instance, pad 0xFF
  logic       b_wr_start, b_wr_en, b_rd_v;
  logic [7:0] b_wr_data, b_rd_data;
  logic [3:0] b_wr_row, b_wr_col, b_rd_x, b_rd_y;
  logic       b_wr_done, b_fv, b_rd_dv, b_rd_oob;

  image_bram_2d #(.DATA_W(8), .ROWS(12), .COLS(12), .ADDR_W(4), .PAD_VAL(8'h00)) u_a (
    .clk(clk), .rst(rst), .wr_start(a_wr_start), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .wr_row(a_wr_row), .wr_col(a_wr_col), .wr_done(a_wr_done), .frame_valid(a_fv),
    .rd_v(a_rd_v), .rd_x(a_rd_x), .rd_y(a_rd_y), .rd_data(a_rd_data),
    .rd_data_valid(a_rd_dv), .rd_oob(a_rd_oob));

  image_bram_2d #(.DATA_W(8), .ROWS(4), .COLS(6), .ADDR_W(4), .PAD_VAL(8'hFF)) u_b (
    .clk(clk), .rst(rst), .wr_start(b_wr_start), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .wr_row(b_wr_row), .wr_col(b_wr_col), .wr_done(b_wr_done), .frame_valid(b_fv),
    .rd_v(b_rd_v), .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_data(b_rd_data),
    .rd_data_valid(b_rd_dv), .rd_oob(b_rd_oob));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: linear raster position plus a frame array.
  int m_pos, m_data;
  bit m_fv, m_done, m_dv, m_oob;
  int m_mem [R][C];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_a_all();
    check_eq("wr_row", int'(a_wr_row), m_pos / C);
    check_eq("wr_col", int'(a_wr_col), m_pos % C);
    check_eq("wr_done", int'(a_wr_done), int'(m_done));
    check_eq("frame_valid", int'(a_fv), int'(m_fv));
    check_eq("rd_data_valid", int'(a_rd_dv), int'(m_dv));
    check_eq("rd_data", int'(a_rd_data), m_data);
    check_eq("rd_oob", int'(a_rd_oob), int'(m_oob));
  endtask

  // One clock of traffic on the 12x12 instance, model advanced alongside.
  task automatic step(input bit ws, input bit we, input int wd, input bit rv, input int rx, input int ry);
    a_wr_start = ws;
    a_wr_en    = we;
    a_wr_data  = wd[7:0];
    a_rd_v     = rv;
    a_rd_x     = rx[3:0];
    a_rd_y     = ry[3:0];
    if (rv) begin
      m_dv  = 1'b1;
      m_oob = (rx >= R) || (ry >= C);
      m_data = m_oob ? 0 : m_mem[rx][ry];
    end else begin
      m_dv = 1'b0;
    end
    if (ws) begin
      m_pos = 0;
      m_fv  = 1'b0;
    end
    m_done = 1'b0;
    if (we) begin
      m_mem[m_pos / C][m_pos % C] = wd & 8'hFF;
      m_pos++;
      if (m_pos == R * C) begin
        m_pos  = 0;
        m_done = 1'b1;
        m_fv   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_a_all();
    a_wr_start = 1'b0;
    a_wr_en    = 1'b0;
    a_rd_v     = 1'b0;
  endtask

  task automatic model_reset();
    m_pos = 0; m_fv = 0; m_done = 0; m_dv = 0; m_oob = 0; m_data = 0;
  endtask

  initial begin
    int done_cnt, dv_run;
    rst = 1'b1;
    a_wr_start = 0; a_wr_en = 0; a_wr_data = 0; a_rd_v = 0; a_rd_x = 0; a_rd_y = 0;
    b_wr_start = 0; b_wr_en = 0; b_wr_data = 0; b_rd_v = 0; b_rd_x = 0; b_rd_y = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_a_all();
    rst = 1'b0;

    // Scenario 1: full frame of row*12+col
    done_cnt = 0;
    for (int p = 0; p < R * C; p++) begin
      step(0, 1, p, 0, 0, 0);
      done_cnt += int'(a_wr_done);
    end
    step(0, 0, 0, 0, 0, 0);
    done_cnt += int'(a_wr_done);
    check_eq("wr_done_count", done_cnt, 1);
    check_eq("fv_after_frame", int'(a_fv), 1);

    // Scenario 2: in-range and out-of-range reads
    step(0, 0, 0, 1, 5, 7);
    check_eq("rd_5_7", int'(a_rd_data), 67);
    step(0, 0, 0, 1, 12, 3);
    check_eq("rd_12_3_oob", int'(a_rd_oob), 1);
    step(0, 0, 0, 1, 3, 15);
    check_eq("rd_3_15_pad", int'(a_rd_data), 0);

    // Scenario 3: streaming raster reads
    dv_run = 0;
    for (int p = 0; p < R * C; p++) begin
      step(0, 0, 0, 1, p / C, p % C);
      dv_run += int'(a_rd_dv);
    end
    check_eq("stream_valid_run", dv_run, R * C);

    // Scenario 4: partial frame, wr_start with write, in-flight read, reset
    for (int p = 0; p < 30; p++) step(0, 1, p + 1, 0, 0, 0);
    step(1, 1, 8'hAA, 0, 0, 0);
    check_eq("ws_col", int'(a_wr_col), 1);
    check_eq("ws_fv", int'(a_fv), 0);
    for (int p = 0; p < 5; p++) step(0, 1, p + 7, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check_eq("rd_0_0_aa", int'(a_rd_data), 8'hAA);
    rst = 1'b1;
    model_reset();
    #1;
    check_a_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 1, 0, 0);
    check_eq("aa_survives_rst", int'(a_rd_data), 8'hAA);

    // Scenario 5: collision at (2,9), old value 0x21
    for (int p = 0; p < 33; p++) step(0, 1, p + 100, 0, 0, 0);
    step(0, 1, 8'h55, 1, 2, 9);
    check_eq("collide_old", int'(a_rd_data), 8'h21);
    step(0, 0, 0, 1, 2, 9);
    check_eq("collide_new", int'(a_rd_data), 8'h55);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 255),
           $urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom_range(0, 15));
    end

    // Scenario 6: non-square 4x6 instance
    done_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      b_wr_en = 1'b1;
      b_wr_data = 8'(k + 100);
      @(posedge clk);
      #1;
      check_eq("b_wr_row", int'(b_wr_row), ((k + 1) % 24) / 6);
      check_eq("b_wr_col", int'(b_wr_col), ((k + 1) % 24) % 6);
      check_eq("b_wr_done", int'(b_wr_done), (k == 23) ? 1 : 0);
    end
    b_wr_en = 1'b0;
    check_eq("b_fv", int'(b_fv), 1);
    b_rd_v = 1'b1; b_rd_x = 4'd4; b_rd_y = 4'd0;
    @(posedge clk); #1;
    check_eq("b_rd_4_0_pad", int'(b_rd_data), 255);
    check_eq("b_rd_4_0_oob", int'(b_rd_oob), 1);
    b_rd_x = 4'd3; b_rd_y = 4'd5;
    @(posedge clk); #1;
    check_eq("b_rd_3_5", int'(b_rd_data), 3 * 6 + 5 + 100);
    check_eq("b_rd_3_5_oob", int'(b_rd_oob), 0);
    b_rd_x = 4'd0; b_rd_y = 4'd6;
    @(posedge clk); #1;
    check_eq("b_rd_0_6_pad", int'(b_rd_data), 255);
    b_rd_v = 1'b0;
    @(posedge clk); #1;
    check_eq("b_rd_idle_valid", int'(b_rd_dv), 0);
    check_eq("b_rd_hold_oob", int'(b_rd_oob), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
